uart_bus_bridge: RTL and testbench

- Byte-stream adapter between the UART device and its port on tec_riscv_bus.
- TX path: pops 65-bit packets from the bus output FIFO (pndng_uart/pop_uart/D_pop_uart), serializes them MSB-first into bytes and hands them to the UART transmitter.
- RX path: assembles bytes from the UART receiver into 65-bit packets and pushes them into the bus input FIFO (push_uart/D_push_uart).
- Packet bits [bits-1:bits-3] carry the destination id; the bridge treats the rest as opaque.

---
 rtl/uart_bus_bridge_if.sv | 34 +++
 rtl/uart_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_uart_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: bus FIFO port plus UART byte streams of the bridge.
// slave = bridge side, master = bus/UART side.
interface uart_bus_bridge_if #(
  parameter int bits = 65
);
  logic            bus_pndng;
  logic            bus_pop;
  logic [bits-1:0] bus_D_pop;
  logic            bus_push;
  logic [bits-1:0] bus_D_push;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            frm_err;
  logic            chk_err;

  modport slave (
    input  bus_pndng, bus_D_pop,
    input  tx_ready, rx_data, rx_valid,
    output bus_pop, bus_push, bus_D_push,
    output tx_data, tx_valid,
    output frm_err, chk_err
  );

  modport master (
    output bus_pndng, bus_D_pop,
    output tx_ready, rx_data, rx_valid,
    input  bus_pop, bus_push, bus_D_push,
    input  tx_data, tx_valid,
    input  frm_err, chk_err
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: packet <-> byte-stream adapter between UART and bus.
// Optional trailing XOR checksum byte: define UART_BUS_BRIDGE_CHKSUM_EN.
module uart_bus_bridge #(
  parameter int bits = 65
) (
  input logic              clk,
  input logic              reset,
  uart_bus_bridge_if.slave io
);
  localparam int NBYTES = (bits + 7) / 8;
  localparam int W      = 8 * NBYTES;
  localparam int PAD    = W - bits;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
  localparam int NSEND  = NBYTES + 1;
  localparam int RSW    = bits;
`else
  localparam int NSEND  = NBYTES;
  localparam int RSW    = bits - 8;
`endif
  localparam int SW     = 8 * NSEND;
  localparam int CW     = $clog2(NSEND + 1);

  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  tx_state_t       state_q, state_d;
  logic [SW-1:0]   tx_sr;
  logic [CW-1:0]   tx_cnt;
  logic            tx_fire;
  logic [CW-1:0]   rx_cnt;
  logic [RSW-1:0]  rx_sr;
  logic            pad_bad;
  logic            rx_last;

`ifdef UART_BUS_BRIDGE_CHKSUM_EN
  logic [7:0]      rx_ck;

  function automatic logic [7:0] byte_xor(
    input logic [bits-1:0] p
  );
    logic [W-1:0] e;
    logic [7:0]   x;
    e = W'(p);
    x = '0;
    for (int i = 0; i < NBYTES; i++)
      x ^= e[8*i +: 8];
    return x;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= T_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    io.bus_pop  = 1'b0;
    io.tx_valid = 1'b0;
    unique case (state_q)
      T_IDLE: begin
        io.bus_pop = io.bus_pndng;
        if (io.bus_pndng) state_d = T_SEND;
      end
      T_SEND: begin
        io.tx_valid = 1'b1;
        if (io.tx_ready && tx_cnt == CW'(NSEND - 1))
          state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign tx_fire    = io.tx_valid && io.tx_ready;
  assign io.tx_data = tx_sr[SW-1 -: 8];

  // the checksum rides as the last byte of the shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr  <= '0;
      tx_cnt <= '0;
    end else if (io.bus_pop) begin
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      tx_sr  <= {W'(io.bus_D_pop), byte_xor(io.bus_D_pop)};
`else
      tx_sr  <= SW'(io.bus_D_pop);
`endif
      tx_cnt <= '0;
    end else if (tx_fire) begin
      tx_sr  <= tx_sr << 8;
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  assign pad_bad = (io.rx_data >> (8 - PAD)) != 8'd0;
  assign rx_last = rx_cnt == CW'(NSEND - 1);

`ifndef UART_BUS_BRIDGE_CHKSUM_EN
  assign io.chk_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt        <= '0;
      rx_sr         <= '0;
      io.bus_push   <= 1'b0;
      io.bus_D_push <= '0;
      io.frm_err    <= 1'b0;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      io.chk_err    <= 1'b0;
      rx_ck         <= '0;
`endif
    end else begin
      io.bus_push <= 1'b0;
      io.frm_err  <= 1'b0;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      io.chk_err  <= 1'b0;
`endif
      if (io.rx_valid) begin
        if (rx_cnt == '0 && pad_bad) begin
          io.frm_err <= 1'b1;
        end else if (rx_last) begin
          rx_cnt <= '0;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
          if (io.rx_data == rx_ck) begin
            io.bus_push   <= 1'b1;
            io.bus_D_push <= rx_sr;
          end else begin
            io.chk_err    <= 1'b1;
          end
`else
          io.bus_push   <= 1'b1;
          io.bus_D_push <= {rx_sr, io.rx_data};
`endif
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
          rx_sr  <= {rx_sr[RSW-9:0], io.rx_data};
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
          rx_ck  <= (rx_cnt == '0) ? io.rx_data
                                   : rx_ck ^ io.rx_data;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: table vectors, corner sequences and random traffic
// checked against a queue-based packet model.
module tb_uart_bus_bridge;
  localparam int BITS = 65;
  localparam int NB   = 9;
  localparam int PADB = 8 * NB - BITS;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
  localparam int CK   = 1;
`else
  localparam int CK   = 0;
`endif
  localparam int NBT  = NB + CK;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_bus_bridge_if #(.bits(BITS)) io ();

  uart_bus_bridge #(.bits(BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  typedef struct {
    logic [64:0] pkt;
    logic [71:0] bytes;
    logic [15:0] rdy;
  } vec_t;

  vec_t vt[5];
  int   tests = 0;
  int   fails = 0;

  logic [7:0]  mq[$];
  logic        e_push, e_frm, e_chk;
  logic [64:0] e_val;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ck_of(input logic [71:0] b);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB; i++) x ^= b[8*i +: 8];
    return x;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [71:0] b,
                                          input int k);
    if (k < NB) return b[71-8*k -: 8];
    return ck_of(b);
  endfunction

  task automatic tx_run(input logic [64:0] pkt, input logic [15:0] pat,
                        input int nstop, input logic [71:0] b);
    int k = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [7:0] held = 8'h00;
    @(negedge clk);
    io.bus_D_pop = pkt;
    io.bus_pndng = 1'b1;
    #1 chk("tx_pop", io.bus_pop, 1'b1);
    @(posedge clk);
    #1 io.bus_pndng = 1'b0;
    while (k < nstop && cyc < 200) begin
      @(negedge clk);
      io.tx_ready = pat[cyc % 16];
      #1;
      if (cyc == 0) chk("tx_latency", io.tx_valid, 1'b1);
      if (stall) chk("tx_hold", io.tx_data, held);
      if (io.bus_pop) chk("tx_extra_pop", io.bus_pop, 1'b0);
      if (io.tx_valid && io.tx_ready) begin
        chk("tx_byte", io.tx_data, exp_byte(b, k));
        k++;
        stall = 1'b0;
      end else if (io.tx_valid) begin
        stall = 1'b1;
        held = io.tx_data;
      end
      cyc++;
    end
    if (k < nstop) chk("tx_timeout", k, nstop);
    if (nstop == NBT) begin
      @(negedge clk);
      io.tx_ready = 1'b0;
      #1 chk("tx_done_idle", io.tx_valid, 1'b0);
    end
  endtask

  task automatic tx_b2b(input logic [64:0] pkt);
    int npop = 0;
    int c = 0;
    int c0 = 0;
    io.tx_ready = 1'b1;
    io.bus_D_pop = pkt;
    io.bus_pndng = 1'b1;
    while (npop < 2 && c < 60) begin
      @(negedge clk);
      #1;
      if (io.bus_pop) begin
        npop++;
        if (npop == 1) c0 = c;
        else chk("tx_b2b_gap", c - c0, NBT + 1);
      end
      c++;
    end
    if (npop < 2) chk("tx_b2b_timeout", npop, 2);
    @(posedge clk);
    #1 io.bus_pndng = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      #1 c++;
    end while (io.tx_valid && c < 40);
    chk("tx_b2b_drain", io.tx_valid, 1'b0);
    io.tx_ready = 1'b0;
  endtask

  task automatic rx_cycle(input logic v, input logic [7:0] d);
    logic [71:0] acc;
    logic [7:0]  x;
    @(negedge clk);
    io.rx_valid = v;
    io.rx_data  = d;
    #1;
    chk("rx_push", io.bus_push, e_push);
    chk("rx_frm_err", io.frm_err, e_frm);
    chk("rx_chk_err", io.chk_err, e_chk);
    chk("rx_d_push", io.bus_D_push, e_val);
    e_push = 1'b0;
    e_frm  = 1'b0;
    e_chk  = 1'b0;
    if (v) begin
      if (mq.size() == 0 && (d >> (8 - PADB)) != 0) begin
        e_frm = 1'b1;
      end else begin
        mq.push_back(d);
        if (mq.size() == NBT) begin
          acc = '0;
          x = 8'h00;
          for (int i = 0; i < NB; i++) begin
            acc = (acc << 8) | 72'(mq[i]);
            x ^= mq[i];
          end
          if (CK == 0 || mq[NBT-1] == x) begin
            e_push = 1'b1;
            e_val  = acc[64:0];
          end else begin
            e_chk = 1'b1;
          end
          mq.delete();
        end
      end
    end
  endtask

  task automatic rx_send_pkt(input logic [71:0] b, input int gap,
                             input logic bad);
    for (int k = 0; k < NB; k++) begin
      rx_cycle(1'b1, b[71-8*k -: 8]);
      repeat (gap) rx_cycle(1'b0, 8'h00);
    end
    if (CK != 0) rx_cycle(1'b1, ck_of(b) ^ (bad ? 8'h01 : 8'h00));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    io.bus_pndng = 1'b0;
    io.rx_valid  = 1'b0;
    io.tx_ready  = 1'b0;
    #1;
    chk("rst_pop", io.bus_pop, 1'b0);
    chk("rst_push", io.bus_push, 1'b0);
    chk("rst_d_push", io.bus_D_push, 65'h0);
    chk("rst_tx_valid", io.tx_valid, 1'b0);
    chk("rst_tx_data", io.tx_data, 8'h00);
    chk("rst_frm", io.frm_err, 1'b0);
    chk("rst_chk", io.chk_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    e_push = 1'b0;
    e_frm  = 1'b0;
    e_chk  = 1'b0;
    e_val  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] rp;
    vt[0] = '{65'h1_2345_6789_ABCD_EF01, 72'h01_2345_6789_ABCD_EF01,
              16'hFFFF};
    vt[1] = '{65'h1_2345_6789_ABCD_EF01, 72'h01_2345_6789_ABCD_EF01,
              16'h9999};
    vt[2] = '{65'h0, 72'h0, 16'hFFFF};
    vt[3] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 72'h01_FFFF_FFFF_FFFF_FFFF,
              16'h5555};
    vt[4] = '{65'h0_8000_0000_0000_0001, 72'h00_8000_0000_0000_0001,
              16'h3333};
    io.bus_pndng = 1'b0;
    io.bus_D_pop = '0;
    io.tx_ready  = 1'b0;
    io.rx_data   = 8'h00;
    io.rx_valid  = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    foreach (vt[i]) tx_run(vt[i].pkt, vt[i].rdy, NBT, vt[i].bytes);
    foreach (vt[i]) rx_send_pkt(vt[i].bytes, i % 2, 1'b0);
    rx_cycle(1'b0, 8'h00);

    rx_cycle(1'b1, 8'h80);
    rx_send_pkt(vt[0].bytes, 0, 1'b0);
    rx_cycle(1'b0, 8'h00);
    chk("rx_resync_val", io.bus_D_push, vt[0].pkt);

    rx_send_pkt(vt[0].bytes, 0, 1'b1);
    rx_cycle(1'b0, 8'h00);
    rx_send_pkt(vt[0].bytes, 0, 1'b0);
    rx_send_pkt(vt[3].bytes, 0, 1'b0);
    rx_cycle(1'b0, 8'h00);

    tx_b2b(vt[0].pkt);

    fork
      tx_run(vt[1].pkt, vt[1].rdy, NBT, vt[1].bytes);
      rx_send_pkt(vt[4].bytes, 1, 1'b0);
    join
    rx_cycle(1'b0, 8'h00);

    fork
      tx_run(vt[0].pkt, 16'hFFFF, 3, vt[0].bytes);
      begin
        for (int k = 0; k < 4; k++)
          rx_cycle(1'b1, vt[3].bytes[71-8*k -: 8]);
        rx_cycle(1'b0, 8'h00);
      end
    join
    do_reset();
    @(negedge clk);
    #1 chk("rst_no_replay", io.tx_valid, 1'b0);
    rx_send_pkt(vt[0].bytes, 0, 1'b0);
    rx_cycle(1'b0, 8'h00);
    chk("rst_fresh_push", io.bus_D_push, vt[0].pkt);
    tx_run(vt[3].pkt, 16'hFFFF, NBT, vt[3].bytes);

    for (int n = 0; n < 12; n++) begin
      rp = {$urandom_range(0, 1), $urandom(), $urandom()};
      tx_run(rp, 16'($urandom()) | 16'h0001, NBT, 72'(rp));
    end
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0)
        rx_cycle(1'b1, 8'h80 | 8'($urandom()));
      rp = {$urandom_range(0, 1), $urandom(), $urandom()};
      rx_send_pkt(72'(rp), $urandom_range(0, 2),
                  $urandom_range(0, 3) == 0);
    end
    rx_cycle(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
